// File: rtl/img_loader.sv
// -----------------------------------------------------------------------------
// img_loader
//   Accepts a raster-ordered stream of 8-bit grayscale pixels and assembles a
//   full LAPTOP_HEIGHT x LAPTOP_WIDTH frame in laptop_img. When the last pixel
//   lands, laptop_img_rdy pulses for one cycle and the frame is then held
//   stable (no input accepted) until the downstream detector pulses
//   frame_done.
//
// Ports
//   clock          : sole clock, all state updates on posedge
//   reset          : synchronous, active-high; control state only
//   pixel_in       : grayscale pixel byte
//   pixel_valid    : pixel_in valid this cycle
//   sof            : start-of-frame, qualified by pixel_valid; byte is (0,0)
//   pixel_ready    : block accepts a byte this cycle
//   laptop_img     : assembled frame, indexed [row][col]
//   laptop_img_rdy : one-cycle pulse, complete frame valid in laptop_img
//   frame_done     : one-cycle pulse, downstream finished with the frame
//   frame_count    : frames completed since reset (wraps)
//   sof_error      : sticky, sof seen while a frame was partially loaded
// -----------------------------------------------------------------------------
module img_loader #(
    parameter int LAPTOP_WIDTH  = 320,
    parameter int LAPTOP_HEIGHT = 240
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_valid,
    input  logic        sof,
    output logic        pixel_ready,
    output logic [7:0]  laptop_img [LAPTOP_HEIGHT][LAPTOP_WIDTH],
    output logic        laptop_img_rdy,
    input  logic        frame_done,
    output logic [15:0] frame_count,
    output logic        sof_error
);

    localparam int RW = (LAPTOP_HEIGHT > 1) ? $clog2(LAPTOP_HEIGHT) : 1;
    localparam int CW = (LAPTOP_WIDTH  > 1) ? $clog2(LAPTOP_WIDTH)  : 1;
    localparam logic [31:0] LAST_ROW = 32'(LAPTOP_HEIGHT - 1);
    localparam logic [31:0] LAST_COL = 32'(LAPTOP_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RDY,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] row;
    logic [31:0] col;
    logic [31:0] row_next;
    logic [31:0] col_next;
    logic        wr_en;
    logic [RW-1:0] wr_row;
    logic [CW-1:0] wr_col;
    logic        frame_inc;
    logic        sof_err_set;

    // Next-state, address and output decode
    always_comb begin
        state_next     = state;
        row_next       = row;
        col_next       = col;
        pixel_ready    = 1'b0;
        laptop_img_rdy = 1'b0;
        wr_en          = 1'b0;
        wr_row         = row[RW-1:0];
        wr_col         = col[CW-1:0];
        frame_inc      = 1'b0;
        sof_err_set    = 1'b0;

        case (state)
            IDLE: begin
                pixel_ready = 1'b1;
                // Bytes before the first sof are dropped on the floor.
                if (pixel_valid && sof) begin
                    wr_en      = 1'b1;
                    wr_row     = '0;
                    wr_col     = '0;
                    row_next   = 32'd0;
                    col_next   = 32'd1;
                    state_next = LOAD;
                end
            end

            LOAD: begin
                pixel_ready = 1'b1;
                if (pixel_valid) begin
                    wr_en = 1'b1;
                    if (sof) begin
                        // Restart mid-frame: the partial frame is overwritten.
                        wr_row      = '0;
                        wr_col      = '0;
                        row_next    = 32'd0;
                        col_next    = 32'd1;
                        sof_err_set = 1'b1;
                    end else if ((row == LAST_ROW) && (col == LAST_COL)) begin
                        row_next   = 32'd0;
                        col_next   = 32'd0;
                        frame_inc  = 1'b1;
                        state_next = RDY;
                    end else if (col == LAST_COL) begin
                        col_next = 32'd0;
                        row_next = row + 32'd1;
                    end else begin
                        col_next = col + 32'd1;
                    end
                end
            end

            RDY: begin
                laptop_img_rdy = 1'b1;
                state_next     = HOLD;
            end

            HOLD: begin
                if (frame_done) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            row         <= 32'd0;
            col         <= 32'd0;
            frame_count <= 16'd0;
            sof_error   <= 1'b0;
        end else begin
            state <= state_next;
            row   <= row_next;
            col   <= col_next;
            if (frame_inc) begin
                frame_count <= frame_count + 16'd1;
            end
            if (sof_err_set) begin
                sof_error <= 1'b1;
            end
        end
    end

    // Frame storage: never cleared; a transfer coinciding with reset is ignored.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            laptop_img[wr_row][wr_col] <= pixel_in;
        end
    end

endmodule

// File: tb/tb_img_loader.sv
module tb_img_loader;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int BW = 320;
    localparam int BH = 240;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Small 4x3 instance
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic        sof = 1'b0;
    logic [7:0]  din = 8'd0;
    logic        done = 1'b0;
    logic        ready;
    logic        rdy;
    logic [7:0]  img [H][W];
    logic [15:0] fc;
    logic        se;

    img_loader #(.LAPTOP_WIDTH(W), .LAPTOP_HEIGHT(H)) dut (
        .clock(clk), .reset(rst), .pixel_in(din), .pixel_valid(vld), .sof(sof),
        .pixel_ready(ready), .laptop_img(img), .laptop_img_rdy(rdy),
        .frame_done(done), .frame_count(fc), .sof_error(se)
    );

    // Default-size 320x240 instance
    logic        b_rst = 1'b1;
    logic        b_vld = 1'b0;
    logic        b_sof = 1'b0;
    logic [7:0]  b_din = 8'd0;
    logic        b_done = 1'b0;
    logic        b_ready;
    logic        b_rdy;
    logic [7:0]  b_img [BH][BW];
    logic [15:0] b_fc;
    logic        b_se;

    img_loader dut_big (
        .clock(clk), .reset(b_rst), .pixel_in(b_din), .pixel_valid(b_vld), .sof(b_sof),
        .pixel_ready(b_ready), .laptop_img(b_img), .laptop_img_rdy(b_rdy),
        .frame_done(b_done), .frame_count(b_fc), .sof_error(b_se)
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_pulse = 0;
    bit prev_rdy = 1'b0;

    // Reference model: linear pixel position within the current frame
    // (-1 when no frame is being loaded), plus the post-frame phases.
    int m_pos  = -1;
    bit m_rdy  = 1'b0;
    bit m_hold = 1'b0;
    int m_fc   = 0;
    bit m_se   = 1'b0;
    int m_img[$];

    typedef struct {
        bit         r;
        bit         v;
        bit         s;
        bit         fd;
        logic [7:0] d;
        bit         e_ready;
        bit         e_rdy;
        int         e_fc;
        bit         e_se;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input bit s, input logic [7:0] d, input bit fd);
        if (r) begin
            m_pos = -1; m_rdy = 1'b0; m_hold = 1'b0; m_fc = 0; m_se = 1'b0;
        end else if (m_rdy) begin
            m_rdy = 1'b0; m_hold = 1'b1;
        end else if (m_hold) begin
            if (fd) m_hold = 1'b0;
        end else if (v) begin
            if (s) begin
                if (m_pos >= 0) m_se = 1'b1;
                m_img[0] = int'(d);
                m_pos = 1;
            end else if (m_pos >= 0) begin
                m_img[m_pos] = int'(d);
                m_pos++;
                if (m_pos == W * H) begin
                    m_pos = -1;
                    m_rdy = 1'b1;
                    m_fc  = (m_fc + 1) % 65536;
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input bit r, input bit v, input bit s, input logic [7:0] d, input bit fd);
        @(negedge clk);
        rst = r; vld = v; sof = s; din = d; done = fd;
        model_edge(r, v, s, d, fd);
        @(posedge clk);
        #1;
        check("ready", int'(ready), int'(!(m_rdy || m_hold)));
        check("rdy", int'(rdy), int'(m_rdy));
        check("frame_count", int'(fc), m_fc);
        check("sof_error", int'(se), int'(m_se));
        if (rdy) begin
            n_pulse++;
            check("rdy_not_back_to_back", int'(prev_rdy), 0);
        end
        prev_rdy = rdy;
    endtask

    task automatic check_img_model(input string name);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                check(name, int'(img[2'(r)][2'(c)]), m_img[r * W + c]);
    endtask

    task automatic check_img_linear(input string name, input int base);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                check(name, int'(img[2'(r)][2'(c)]), base + 4 * r + c);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int rdy_cyc;
        for (int i = 0; i < W * H; i++) m_img.push_back(0);

        // ---------------- table: reset, 12 bytes, HOLD flooding, frame_done
        v = '{r:1, v:0, s:0, fd:0, d:8'd0, e_ready:1, e_rdy:0, e_fc:0, e_se:0};
        tbl.push_back(v);
        for (int k = 0; k < 12; k++) begin
            v = '{r:0, v:1, s:(k == 0), fd:0, d:8'(k), e_ready:(k < 11), e_rdy:(k == 11),
                  e_fc:((k == 11) ? 1 : 0), e_se:0};
            tbl.push_back(v);
        end
        for (int k = 0; k < 20; k++) begin
            // frame_done in the RDY cycle and a sof in HOLD must both be ignored
            v = '{r:0, v:1, s:(k == 5), fd:(k == 0), d:8'hFF, e_ready:0, e_rdy:0, e_fc:1, e_se:0};
            tbl.push_back(v);
        end
        v = '{r:0, v:0, s:0, fd:1, d:8'd0, e_ready:1, e_rdy:0, e_fc:1, e_se:0};
        tbl.push_back(v);
        v = '{r:0, v:0, s:0, fd:0, d:8'd0, e_ready:1, e_rdy:0, e_fc:1, e_se:0};
        tbl.push_back(v);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].fd);
            check("tbl_ready", int'(ready), int'(tbl[i].e_ready));
            check("tbl_rdy", int'(rdy), int'(tbl[i].e_rdy));
            check("tbl_frame_count", int'(fc), tbl[i].e_fc);
            check("tbl_sof_error", int'(se), int'(tbl[i].e_se));
        end
        check_img_linear("img_back_to_back", 0);

        // ---------------- valid toggling 1/0
        step(1, 0, 0, 8'd0, 0);
        n_pulse = 0;
        for (int k = 0; k < 12; k++) begin
            step(0, 1, (k == 0), 8'(k), 0);
            if (k == 11) begin
                check("toggle_rdy_after_last", int'(rdy), 1);
                check("toggle_pulses_at_last", n_pulse, 1);
            end else begin
                step(0, 0, 0, 8'hEE, 0);
            end
        end
        step(0, 0, 0, 8'd0, 0);
        step(0, 0, 0, 8'd0, 0);
        check("toggle_pulses_total", n_pulse, 1);
        check_img_linear("img_toggle", 0);
        step(0, 0, 0, 8'd0, 1);

        // ---------------- sof restart at byte 5
        step(1, 0, 0, 8'd0, 0);
        n_pulse = 0;
        for (int k = 0; k < 5; k++) step(0, 1, (k == 0), 8'(k), 0);
        for (int k = 0; k < 12; k++) step(0, 1, (k == 0), 8'(100 + k), 0);
        step(0, 0, 0, 8'd0, 0);
        step(0, 0, 0, 8'd0, 0);
        check("restart_pulses", n_pulse, 1);
        check("restart_sof_error", int'(se), 1);
        check("restart_frame_count", int'(fc), 1);
        check_img_linear("img_restart", 100);

        // ---------------- bytes without sof, then reset mid-frame
        step(1, 0, 0, 8'd0, 0);
        n_pulse = 0;
        for (int k = 0; k < 5; k++) step(0, 1, 0, 8'(200 + k), 0);
        for (int k = 0; k < 7; k++) step(0, 1, (k == 0), 8'(k), 0);
        step(1, 1, 0, 8'd7, 0);
        for (int k = 0; k < 12; k++) step(0, 0, 0, 8'd0, 0);
        check("abandon_pulses", n_pulse, 0);
        check("abandon_frame_count", int'(fc), 0);

        // ---------------- randomized traffic against the model
        step(1, 0, 0, 8'd0, 0);
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 200) == 0, ($urandom % 10) < 7, ($urandom % 25) == 0,
                 8'($urandom), ($urandom % 8) == 0);
            if (m_rdy || m_hold) check_img_model("img_random");
        end
        step(1, 0, 0, 8'd0, 0);

        // ---------------- default 320x240 frame, bytes (r+c) mod 256
        @(negedge clk);
        b_rst = 1'b1;
        @(posedge clk);
        #1;
        rdy_cyc = -1;
        // The first byte occupies cycle 1; the sample after edge p belongs to cycle p+2.
        for (int p = 0; p < BW * BH; p++) begin
            @(negedge clk);
            b_rst = 1'b0; b_vld = 1'b1; b_sof = (p == 0);
            b_din = 8'((p / BW + p % BW) % 256);
            @(posedge clk);
            #1;
            if (b_rdy && rdy_cyc < 0) rdy_cyc = p + 2;
        end
        @(negedge clk);
        b_vld = 1'b0; b_sof = 1'b0;
        if (rdy_cyc < 0) begin
            for (int t = 0; t < 20 && rdy_cyc < 0; t++) begin
                @(posedge clk);
                #1;
                if (b_rdy) rdy_cyc = BW * BH + 2 + t;
            end
        end
        check("big_rdy_cycle", rdy_cyc, BW * BH + 1);
        check("big_frame_count", int'(b_fc), 1);
        check("big_sof_error", int'(b_se), 0);
        check("big_ready_in_hold", int'(b_ready), 0);
        check("big_img_0_0", int'(b_img[0][0]), 0);
        check("big_img_239_319", int'(b_img[239][319]), 46);
        check("big_img_100_200", int'(b_img[100][200]), 44);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
